// File: rtl/cdb_arbiter_if.sv
// Completion handshake and common data bus bundle between the execute-stage
// functional units and the CDB arbiter.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int PREG_W = 6
);
  logic [N_REQ-1:0]        fu_valid;
  logic [N_REQ*PREG_W-1:0] fu_tag;
  logic [N_REQ-1:0]        fu_ready;
  logic                    squash;
  logic                    cdb_en;
  logic [PREG_W-1:0]       cdb_tag;

  // master: the arbiter, which owns the bus; slave: the functional units
  modport master (
    input  fu_valid, fu_tag, squash,
    output fu_ready, cdb_en, cdb_tag
  );

  modport slave (
    output fu_valid, fu_tag, squash,
    input  fu_ready, cdb_en, cdb_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one FU completion per cycle onto the registered CDB.
// Optional per-requester one-entry holding buffers: define CDB_HOLD_BUF_EN.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int PREG_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.master bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [PTR_W-1:0]  rr_ptr_next;
  logic              cdb_en_reg;
  logic [PREG_W-1:0] cdb_tag_reg;

  logic [PREG_W-1:0] live_tag [N_REQ];
  logic [PREG_W-1:0] cand_tag [N_REQ];
  logic [N_REQ-1:0]  cand_valid;
  logic [N_REQ-1:0]  upper_mask;
  logic [N_REQ-1:0]  upper_req;
  logic [N_REQ-1:0]  pick_vec;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  ready_raw;
  logic              any_grant;
  logic [PTR_W-1:0]  winner_idx;
  logic [PREG_W-1:0] winner_tag;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign live_tag[gi]   = bus.fu_tag[gi*PREG_W +: PREG_W];
      assign upper_mask[gi] = (PTR_W'(gi) >= rr_ptr_reg);
    end
  endgenerate

`ifdef CDB_HOLD_BUF_EN
  logic [N_REQ-1:0]  buf_valid_reg;
  logic [PREG_W-1:0] buf_tag_reg [N_REQ];
  logic [N_REQ-1:0]  accept;
  logic [N_REQ-1:0]  buf_load;

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_buf
      // A buffered entry is older than the live input, so it always wins.
      assign cand_valid[gi] = buf_valid_reg[gi] | bus.fu_valid[gi];
      assign cand_tag[gi]   = buf_valid_reg[gi] ? buf_tag_reg[gi] : live_tag[gi];
      assign ready_raw[gi]  = ~buf_valid_reg[gi] | grant[gi];
      assign accept[gi]     = bus.fu_valid[gi] & bus.fu_ready[gi];
      // Live tag goes straight to the CDB only when granted with an empty buffer.
      assign buf_load[gi]   = accept[gi] & (buf_valid_reg[gi] | ~grant[gi]);
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid_reg <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        buf_tag_reg[i] <= '0;
      end
    end else if (bus.squash) begin
      buf_valid_reg <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          buf_valid_reg[i] <= buf_valid_reg[i] & accept[i];
        end else begin
          buf_valid_reg[i] <= buf_valid_reg[i] | accept[i];
        end
        if (buf_load[i]) begin
          buf_tag_reg[i] <= live_tag[i];
        end
      end
    end
  end
`else
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_live
      assign cand_valid[gi] = bus.fu_valid[gi];
      assign cand_tag[gi]   = live_tag[gi];
      assign ready_raw[gi]  = grant[gi];
    end
  endgenerate
`endif

  // Circular search from rr_ptr: prefer requesters at or above the pointer,
  // otherwise wrap to the lowest-numbered candidate.
  assign upper_req = cand_valid & upper_mask;
  assign pick_vec  = (|upper_req) ? upper_req : cand_valid;
  assign grant     = bus.squash ? '0 : (pick_vec & (~pick_vec + N_REQ'(1)));
  assign any_grant = |grant;

  always_comb begin
    winner_idx = '0;
    winner_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        winner_idx = winner_idx | PTR_W'(i);
        winner_tag = winner_tag | cand_tag[i];
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (any_grant) begin
      if (winner_idx == PTR_W'(N_REQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = winner_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg  <= '0;
      cdb_en_reg  <= 1'b0;
      cdb_tag_reg <= '0;
    end else begin
      rr_ptr_reg  <= rr_ptr_next;
      cdb_en_reg  <= any_grant;
      cdb_tag_reg <= any_grant ? winner_tag : '0;
    end
  end

  assign bus.fu_ready = (reset | bus.squash) ? '0 : ready_raw;
  assign bus.cdb_en   = cdb_en_reg;
  assign bus.cdb_tag  = cdb_tag_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; expectations follow the
// CDB_HOLD_BUF_EN setting where the buffers change fu_ready or ordering.
module tb_cdb_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  cdb_arbiter_if #(.N_REQ(4), .PREG_W(6)) bus ();

  cdb_arbiter #(.N_REQ(4), .PREG_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] exp_rdy;
    bus.fu_valid = 4'b1111;
    bus.fu_tag   = {6'd35, 6'd34, 6'd33, 6'd32};
    tick;
    checks++; if (bus.fu_ready !== 4'b0000) begin failures++; $display("FAIL reset_hold_ready: got %b expected 0000", bus.fu_ready); end
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL reset_hold_en: got %b expected 0", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd0) begin failures++; $display("FAIL reset_hold_tag: got %0d expected 0", bus.cdb_tag); end
    bus.fu_valid = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    bus.fu_valid = 4'b0100;
    bus.fu_tag   = {6'd0, 6'd33, 6'd0, 6'd0};
    tick;
    checks++; if (bus.cdb_en !== 1'b1) begin failures++; $display("FAIL reset_pre_en: got %b expected 1", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd33) begin failures++; $display("FAIL reset_pre_tag: got %0d expected 33", bus.cdb_tag); end
    bus.fu_valid = 4'b1010;
    bus.fu_tag   = {6'd43, 6'd0, 6'd41, 6'd0};
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL reset_mid_en: got %b expected 0", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd0) begin failures++; $display("FAIL reset_mid_tag: got %0d expected 0", bus.cdb_tag); end
    checks++; if (bus.fu_ready !== 4'b0000) begin failures++; $display("FAIL reset_mid_ready: got %b expected 0000", bus.fu_ready); end
    #1 reset = 1'b0;
    #1;
`ifdef CDB_HOLD_BUF_EN
    exp_rdy = 4'b1111;
`else
    exp_rdy = 4'b0010;
`endif
    checks++; if (bus.fu_ready !== exp_rdy) begin failures++; $display("FAIL reset_first_search: got %b expected %b", bus.fu_ready, exp_rdy); end
    tick;
    checks++; if (bus.cdb_en !== 1'b1) begin failures++; $display("FAIL reset_first_en: got %b expected 1", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd41) begin failures++; $display("FAIL reset_first_tag: got %0d expected 41", bus.cdb_tag); end
`ifdef CDB_HOLD_BUF_EN
    bus.fu_valid = 4'b0000;
    exp_rdy = 4'b1111;
`else
    bus.fu_valid = 4'b1000;
    exp_rdy = 4'b1000;
`endif
    #1;
    checks++; if (bus.fu_ready !== exp_rdy) begin failures++; $display("FAIL reset_second_ready: got %b expected %b", bus.fu_ready, exp_rdy); end
    tick;
    checks++; if (bus.cdb_en !== 1'b1) begin failures++; $display("FAIL reset_second_en: got %b expected 1", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd43) begin failures++; $display("FAIL reset_second_tag: got %0d expected 43", bus.cdb_tag); end
    bus.fu_valid = 4'b0000;
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL reset_idle_en: got %b expected 0", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd0) begin failures++; $display("FAIL reset_idle_tag: got %0d expected 0", bus.cdb_tag); end
    $display("test_reset done");
  endtask

  task automatic test_single;
    logic [3:0] exp_rdy;
    bus.fu_valid = 4'b0100;
    bus.fu_tag   = {6'd0, 6'd33, 6'd0, 6'd0};
    #1;
`ifdef CDB_HOLD_BUF_EN
    exp_rdy = 4'b1111;
`else
    exp_rdy = 4'b0100;
`endif
    checks++; if (bus.fu_ready !== exp_rdy) begin failures++; $display("FAIL single_ready: got %b expected %b", bus.fu_ready, exp_rdy); end
    tick;
    checks++; if (bus.cdb_en !== 1'b1) begin failures++; $display("FAIL single_en: got %b expected 1", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd33) begin failures++; $display("FAIL single_tag: got %0d expected 33", bus.cdb_tag); end
    bus.fu_valid = 4'b0000;
    #1;
`ifdef CDB_HOLD_BUF_EN
    exp_rdy = 4'b1111;
`else
    exp_rdy = 4'b0000;
`endif
    checks++; if (bus.fu_ready !== exp_rdy) begin failures++; $display("FAIL single_idle_ready: got %b expected %b", bus.fu_ready, exp_rdy); end
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL single_off_en: got %b expected 0", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd0) begin failures++; $display("FAIL single_off_tag: got %0d expected 0", bus.cdb_tag); end
    $display("test_single done");
  endtask

  task automatic test_idle_wrap;
    logic [3:0] exp_rdy;
    bus.fu_valid = 4'b1000;
    bus.fu_tag   = {6'd50, 6'd0, 6'd0, 6'd0};
    #1;
`ifdef CDB_HOLD_BUF_EN
    exp_rdy = 4'b1111;
`else
    exp_rdy = 4'b1000;
`endif
    checks++; if (bus.fu_ready !== exp_rdy) begin failures++; $display("FAIL wrap_ready: got %b expected %b", bus.fu_ready, exp_rdy); end
    tick;
    checks++; if (bus.cdb_en !== 1'b1) begin failures++; $display("FAIL wrap_en: got %b expected 1", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd50) begin failures++; $display("FAIL wrap_tag: got %0d expected 50", bus.cdb_tag); end
    bus.fu_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL idle_en[%0d]: got %b expected 0", k, bus.cdb_en); end
    end
    $display("test_idle_wrap done");
  endtask

  task automatic test_contention;
    logic [3:0] exp_rdy [5];
    logic [5:0] exp_tag;
`ifdef CDB_HOLD_BUF_EN
    exp_rdy = '{4'b1111, 4'b0011, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    bus.fu_valid = 4'b1111;
    bus.fu_tag   = {6'd35, 6'd34, 6'd33, 6'd32};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.fu_ready !== exp_rdy[c]) begin failures++; $display("FAIL contend_ready[%0d]: got %b expected %b", c, bus.fu_ready, exp_rdy[c]); end
      tick;
      exp_tag = 6'(32 + (c % 4));
      checks++; if (bus.cdb_en !== 1'b1) begin failures++; $display("FAIL contend_en[%0d]: got %b expected 1", c, bus.cdb_en); end
      checks++; if (bus.cdb_tag !== exp_tag) begin failures++; $display("FAIL contend_tag[%0d]: got %0d expected %0d", c, bus.cdb_tag, exp_tag); end
    end
    bus.fu_valid = 4'b0000;
`ifdef CDB_HOLD_BUF_EN
    for (int c = 0; c < 4; c++) begin
      tick;
      exp_tag = 6'(32 + ((c + 1) % 4));
      checks++; if (bus.cdb_tag !== exp_tag || bus.cdb_en !== 1'b1) begin failures++; $display("FAIL drain_tag[%0d]: got en=%b tag=%0d expected en=1 tag=%0d", c, bus.cdb_en, bus.cdb_tag, exp_tag); end
    end
`endif
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL contend_end_en: got %b expected 0", bus.cdb_en); end
    $display("test_contention done");
  endtask

  task automatic test_squash;
    logic [3:0] exp_rdy;
    bus.fu_valid = 4'b0001;
    bus.fu_tag   = {6'd0, 6'd0, 6'd0, 6'd7};
    tick;
    checks++; if (bus.cdb_tag !== 6'd7) begin failures++; $display("FAIL squash_pre_tag: got %0d expected 7", bus.cdb_tag); end
    bus.fu_valid = 4'b0110;
    bus.fu_tag   = {6'd0, 6'd42, 6'd41, 6'd0};
    bus.squash   = 1'b1;
    #1;
    checks++; if (bus.fu_ready !== 4'b0000) begin failures++; $display("FAIL squash_ready: got %b expected 0000", bus.fu_ready); end
    checks++; if (bus.cdb_en !== 1'b1 || bus.cdb_tag !== 6'd7) begin failures++; $display("FAIL squash_inflight: got en=%b tag=%0d expected en=1 tag=7", bus.cdb_en, bus.cdb_tag); end
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL squash_next_en: got %b expected 0", bus.cdb_en); end
    checks++; if (bus.cdb_tag !== 6'd0) begin failures++; $display("FAIL squash_next_tag: got %0d expected 0", bus.cdb_tag); end
    bus.squash = 1'b0;
    #1;
`ifdef CDB_HOLD_BUF_EN
    exp_rdy = 4'b1111;
`else
    exp_rdy = 4'b0010;
`endif
    checks++; if (bus.fu_ready !== exp_rdy) begin failures++; $display("FAIL squash_ptr_kept: got %b expected %b", bus.fu_ready, exp_rdy); end
    tick;
    checks++; if (bus.cdb_tag !== 6'd41) begin failures++; $display("FAIL squash_after_tag1: got %0d expected 41", bus.cdb_tag); end
`ifdef CDB_HOLD_BUF_EN
    bus.fu_valid = 4'b0000;
    exp_rdy = 4'b1111;
`else
    bus.fu_valid = 4'b0100;
    exp_rdy = 4'b0100;
`endif
    #1;
    checks++; if (bus.fu_ready !== exp_rdy) begin failures++; $display("FAIL squash_after_ready2: got %b expected %b", bus.fu_ready, exp_rdy); end
    tick;
    checks++; if (bus.cdb_tag !== 6'd42) begin failures++; $display("FAIL squash_after_tag2: got %0d expected 42", bus.cdb_tag); end
    bus.fu_valid = 4'b0000;
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL squash_end_en: got %b expected 0", bus.cdb_en); end
    $display("test_squash done");
  endtask

`ifdef CDB_HOLD_BUF_EN
  task automatic test_buffered;
    bus.fu_valid = 4'b1011;
    bus.fu_tag   = {6'd43, 6'd0, 6'd41, 6'd40};
    #1;
    checks++; if (bus.fu_ready !== 4'b1111) begin failures++; $display("FAIL buf_accept_ready: got %b expected 1111", bus.fu_ready); end
    tick;
    checks++; if (bus.cdb_tag !== 6'd43) begin failures++; $display("FAIL buf_tag43: got %0d expected 43", bus.cdb_tag); end
    bus.fu_valid = 4'b0010;
    bus.fu_tag   = {6'd0, 6'd0, 6'd45, 6'd0};
    #1;
    checks++; if (bus.fu_ready !== 4'b1101) begin failures++; $display("FAIL buf_full_ready: got %b expected 1101", bus.fu_ready); end
    tick;
    checks++; if (bus.cdb_tag !== 6'd40) begin failures++; $display("FAIL buf_tag40: got %0d expected 40", bus.cdb_tag); end
    #1;
    checks++; if (bus.fu_ready !== 4'b1111) begin failures++; $display("FAIL buf_refill_ready: got %b expected 1111", bus.fu_ready); end
    tick;
    checks++; if (bus.cdb_tag !== 6'd41) begin failures++; $display("FAIL buf_tag41: got %0d expected 41", bus.cdb_tag); end
    bus.fu_valid = 4'b0000;
    tick;
    checks++; if (bus.cdb_tag !== 6'd45) begin failures++; $display("FAIL buf_tag45: got %0d expected 45", bus.cdb_tag); end
    bus.fu_valid = 4'b1010;
    bus.fu_tag   = {6'd43, 6'd0, 6'd41, 6'd0};
    tick;
    checks++; if (bus.cdb_tag !== 6'd43) begin failures++; $display("FAIL bsq_tag43: got %0d expected 43", bus.cdb_tag); end
    bus.fu_valid = 4'b0100;
    bus.fu_tag   = {6'd0, 6'd42, 6'd0, 6'd0};
    bus.squash   = 1'b1;
    #1;
    checks++; if (bus.fu_ready !== 4'b0000) begin failures++; $display("FAIL bsq_ready: got %b expected 0000", bus.fu_ready); end
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL bsq_en: got %b expected 0", bus.cdb_en); end
    bus.squash   = 1'b0;
    bus.fu_valid = 4'b0000;
    #1;
    checks++; if (bus.fu_ready !== 4'b1111) begin failures++; $display("FAIL bsq_cleared_ready: got %b expected 1111", bus.fu_ready); end
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL bsq_no41: got en=%b tag=%0d expected en=0", bus.cdb_en, bus.cdb_tag); end
    bus.fu_valid = 4'b1001;
    bus.fu_tag   = {6'd53, 6'd0, 6'd0, 6'd52};
    tick;
    checks++; if (bus.cdb_tag !== 6'd52) begin failures++; $display("FAIL bsq_ptr_tag52: got %0d expected 52", bus.cdb_tag); end
    bus.fu_valid = 4'b0000;
    tick;
    checks++; if (bus.cdb_tag !== 6'd53) begin failures++; $display("FAIL bsq_tag53: got %0d expected 53", bus.cdb_tag); end
    tick;
    checks++; if (bus.cdb_en !== 1'b0) begin failures++; $display("FAIL bsq_end_en: got %b expected 0", bus.cdb_en); end
    $display("test_buffered done");
  endtask
`endif

  initial begin
    bus.fu_valid = '0;
    bus.fu_tag   = '0;
    bus.squash   = 1'b0;
    test_reset;
    test_single;
    test_idle_wrap;
    test_contention;
    test_squash;
`ifdef CDB_HOLD_BUF_EN
    test_buffered;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
